// File: rtl/alu_exec_pkg.sv
// Shared opcodes, flag positions, FSM encoding and default sizes for the
// alu_exec execute stage and its sequential multiplier.
package alu_exec_pkg;

   localparam int WIDTH_DEF = 16;
   localparam int NREGS_DEF = 16;
   localparam int NFLAGS    = 5;

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_CMP = 4'd2;
   localparam logic [3:0] OP_AND = 4'd3;
   localparam logic [3:0] OP_OR  = 4'd4;
   localparam logic [3:0] OP_XOR = 4'd5;
   localparam logic [3:0] OP_MOV = 4'd6;
   localparam logic [3:0] OP_LSH = 4'd7;
   localparam logic [3:0] OP_ASH = 4'd8;
   localparam logic [3:0] OP_MUL = 4'd9;
   localparam logic [3:0] OP_LUI = 4'd10;

   // Bit positions inside flags = {C,L,F,Z,N}.
   localparam int FLAG_C = 4;
   localparam int FLAG_L = 3;
   localparam int FLAG_F = 2;
   localparam int FLAG_Z = 1;
   localparam int FLAG_N = 0;

   typedef enum logic [1:0] {
      S_IDLE,
      S_EXEC,
      S_MUL,
      S_WB
   } state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add multiplier: loads on go, runs WIDTH iterations and raises done in
// the last iteration with the low WIDTH bits of a*b on product.
module alu_mul_seq
   import alu_exec_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             go,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] product,
   output logic             done
);

   localparam int CW = $clog2(WIDTH);

   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] mplier;
   logic [WIDTH-1:0] acc;
   logic [CW-1:0]    cnt;
   logic             running;

   // The last partial product is added combinationally so the final sum is
   // ready in the same cycle done is raised.
   always_comb begin
      product = acc + (mplier[0] ? mcand : '0);
      done    = running && (cnt == CW'(WIDTH - 1));
   end

   // NOTE: sequential state is assigned only with <= so every flop sees the
   // pre-edge values of the others.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mcand   <= '0;
         mplier  <= '0;
         acc     <= '0;
         cnt     <= '0;
         running <= 1'b0;
      end else if (go) begin
         mcand   <= a;
         mplier  <= b;
         acc     <= '0;
         cnt     <= '0;
         running <= 1'b1;
      end else if (running) begin
         acc    <= product;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         if (done) begin
            running <= 1'b0;
            cnt     <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/alu_exec.sv
// Execute stage for the register bank: captures operands on accept, computes
// one operation (MUL via alu_mul_seq) and drives a registered one-hot write.
module alu_exec
   import alu_exec_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int NREGS = NREGS_DEF
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [WIDTH*NREGS-1:0]     regs,
   input  logic                       start,
   input  logic [3:0]                 opcode,
   input  logic [$clog2(NREGS)-1:0]   rdest,
   input  logic [$clog2(NREGS)-1:0]   rsrc,
   input  logic [WIDTH-1:0]           imm,
   input  logic                       use_imm,
   output logic                       busy,
   output logic                       done,
   output logic [WIDTH-1:0]           ALUBus,
   output logic [NREGS-1:0]           regEnable,
   output logic [NFLAGS-1:0]          flags
);

   state_t                     state;
   logic [WIDTH-1:0]           a_sel, b_sel, a_q, b_q;
   logic [3:0]                 op_q;
   logic [$clog2(NREGS)-1:0]   rdest_q;
   logic [WIDTH:0]             sum;
   logic [4:0]                 sh_mag;
   logic [WIDTH-1:0]           alu_res, mul_product;
   logic [NFLAGS-1:0]          alu_flags;
   logic                       alu_wr, mul_go, mul_done;

   always_comb begin
      a_sel  = regs[rdest*WIDTH +: WIDTH];
      b_sel  = use_imm ? imm : regs[rsrc*WIDTH +: WIDTH];
      mul_go = (state == S_IDLE) && start && (opcode == OP_MUL);
   end

   alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
      .clk     (clk),
      .reset   (reset),
      .go      (mul_go),
      .a       (a_sel),
      .b       (b_sel),
      .product (mul_product),
      .done    (mul_done)
   );

   // Shift count is B[4:0] as a signed value; sh_mag is its magnitude (0..16).
   always_comb begin
      // NOTE: every output gets a default first so no path infers a latch.
      alu_res   = a_q;
      alu_flags = flags;
      alu_wr    = 1'b1;
      sum       = '0;
      sh_mag    = b_q[4] ? (~b_q[4:0] + 5'd1) : b_q[4:0];
      case (op_q)
         OP_ADD: begin
            sum                = {1'b0, a_q} + {1'b0, b_q};
            alu_res            = sum[WIDTH-1:0];
            alu_flags[FLAG_C]  = sum[WIDTH];
            alu_flags[FLAG_F]  = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
         end
         OP_SUB: begin
            sum                = {1'b0, a_q} - {1'b0, b_q};
            alu_res            = sum[WIDTH-1:0];
            alu_flags[FLAG_C]  = sum[WIDTH];
            alu_flags[FLAG_F]  = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
         end
         OP_CMP: begin
            alu_wr             = 1'b0;
            alu_flags[FLAG_L]  = a_q < b_q;
            alu_flags[FLAG_N]  = $signed(a_q) < $signed(b_q);
            alu_flags[FLAG_Z]  = a_q == b_q;
         end
         OP_AND: alu_res = a_q & b_q;
         OP_OR:  alu_res = a_q | b_q;
         OP_XOR: alu_res = a_q ^ b_q;
         OP_MOV: alu_res = b_q;
         OP_LSH: alu_res = b_q[4] ? (a_q >> sh_mag) : (a_q << sh_mag);
         OP_ASH: alu_res = b_q[4] ? WIDTH'($signed(a_q) >>> sh_mag) : (a_q << sh_mag);
         OP_LUI: alu_res = {b_q[WIDTH/2-1:0], a_q[WIDTH/2-1:0]};
         default: alu_wr = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= S_IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         ALUBus    <= '0;
         regEnable <= '0;
         flags     <= '0;
         a_q       <= '0;
         b_q       <= '0;
         op_q      <= '0;
         rdest_q   <= '0;
      end else begin
         done      <= 1'b0;
         regEnable <= '0;
         case (state)
            S_IDLE: if (start) begin
               a_q     <= a_sel;
               b_q     <= b_sel;
               op_q    <= opcode;
               rdest_q <= rdest;
               busy    <= 1'b1;
               state   <= (opcode == OP_MUL) ? S_MUL : S_EXEC;
            end
            S_EXEC: begin
               state <= S_WB;
               done  <= 1'b1;
               flags <= alu_flags;
               if (alu_wr) begin
                  ALUBus    <= alu_res;
                  regEnable <= NREGS'(1) << rdest_q;
               end
            end
            S_MUL: if (mul_done) begin
               state     <= S_WB;
               done      <= 1'b1;
               ALUBus    <= mul_product;
               regEnable <= NREGS'(1) << rdest_q;
            end
            S_WB: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_exec.sv
// Bench for alu_exec: acts as the register bank, predicts every output each
// cycle from an arithmetic model, and pins the model with literal results.
module tb_alu_exec;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic [255:0] regs_bus;
   logic         start = 1'b0;
   logic [3:0]   opcode = '0, rdest = '0, rsrc = '0;
   logic [15:0]  imm = '0;
   logic         use_imm = 1'b0;
   logic         busy, done;
   logic [15:0]  alu_bus, reg_en;
   logic [4:0]   flags;

   logic [15:0]  bank   [16] = '{default: 16'h0};
   logic [15:0]  m_regs [16] = '{default: 16'h0};

   int n_checks = 0;
   int n_errors = 0;
   bit run_checks = 1'b0;

   // Expected outputs and the operation the model has in flight.
   logic        e_busy = 1'b0, e_done = 1'b0;
   logic [15:0] e_en = '0, e_bus = '0;
   logic [4:0]  e_flags = '0, p_flags = '0;
   int          m_left = 0, p_res = 0;
   bit          m_inwb = 1'b0, p_wr = 1'b0;
   logic [3:0]  p_rd = '0;

   alu_exec dut (
      .clk       (clk),
      .reset     (reset),
      .regs      (regs_bus),
      .start     (start),
      .opcode    (opcode),
      .rdest     (rdest),
      .rsrc      (rsrc),
      .imm       (imm),
      .use_imm   (use_imm),
      .busy      (busy),
      .done      (done),
      .ALUBus    (alu_bus),
      .regEnable (reg_en),
      .flags     (flags)
   );

   initial forever #5 clk = ~clk;

   always @(posedge clk)
      for (int i = 0; i < 16; i++)
         if (reg_en[i]) bank[i] <= alu_bus;

   always_comb begin
      regs_bus = '0;
      for (int i = 0; i < 16; i++) regs_bus[i*16 +: 16] = bank[i];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Flags {C,L,F,Z,N}; result from plain integer arithmetic on 16-bit values.
   function automatic void model_op(input int op, input int a, input int b, input logic [4:0] fin,
                                    output int res, output logic [4:0] fout, output bit wr);
      int sa, sb, s, sh;
      sa = (a >= 32768) ? a - 65536 : a;
      sb = (b >= 32768) ? b - 65536 : b;
      sh = b % 32;
      if (sh > 15) sh -= 32;
      fout = fin;
      wr   = 1'b1;
      res  = 0;
      case (op)
         0: begin
            s = a + b; res = s % 65536;
            fout[4] = s > 65535;
            fout[2] = (sa + sb > 32767) || (sa + sb < -32768);
         end
         1: begin
            s = a - b; res = (s + 65536) % 65536;
            fout[4] = a < b;
            fout[2] = (sa - sb > 32767) || (sa - sb < -32768);
         end
         2: begin
            wr = 1'b0;
            fout[3] = a < b; fout[0] = sa < sb; fout[1] = a == b;
         end
         3: res = a & b;
         4: res = a | b;
         5: res = a ^ b;
         6: res = b;
         7: res = (sh >= 0) ? (a << sh) % 65536 : a >> (-sh);
         8: res = (sh >= 0) ? (a << sh) % 65536 : (sa >>> (-sh)) & 65535;
         9: res = int'((longint'(a) * longint'(b)) % 65536);
         10: res = (b % 256) * 256 + (a % 256);
         default: wr = 1'b0;
      endcase
   endfunction

   initial begin : model
      int a, b;
      forever begin
         @(posedge clk or negedge reset);
         if (!reset) begin
            m_left = 0; m_inwb = 1'b0;
            e_busy = 1'b0; e_done = 1'b0; e_en = '0; e_bus = '0; e_flags = '0;
         end else begin
            e_done = 1'b0;
            e_en   = '0;
            if (m_inwb) begin
               m_inwb = 1'b0;
               e_busy = 1'b0;
               if (p_wr) m_regs[p_rd] = p_res[15:0];
            end else if (m_left > 0) begin
               m_left--;
               if (m_left == 0) begin
                  m_inwb  = 1'b1;
                  e_done  = 1'b1;
                  e_flags = p_flags;
                  if (p_wr) begin
                     e_en  = 16'h0001 << p_rd;
                     e_bus = p_res[15:0];
                  end
               end
            end else if (start) begin
               a = int'(m_regs[rdest]);
               b = use_imm ? int'(imm) : int'(m_regs[rsrc]);
               model_op(int'(opcode), a, b, e_flags, p_res, p_flags, p_wr);
               p_rd   = rdest;
               m_left = (opcode == 4'd9) ? 16 : 1;
               e_busy = 1'b1;
            end
         end
      end
   end

   initial begin : compare
      forever begin
         @(negedge clk);
         if (run_checks) begin
            check("busy", busy, e_busy);
            check("done", done, e_done);
            check("regEnable", reg_en, e_en);
            check("ALUBus", alu_bus, e_bus);
            check("flags", flags, e_flags);
            for (int i = 0; i < 16; i++) check("bank", regs_bus[i*16 +: 16], m_regs[i]);
         end
      end
   end

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 64) begin @(negedge clk); n++; end
      check("idle_wait", busy, 1'b0);
   endtask

   // Returns at the falling edge of the WB cycle.
   task automatic issue(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs,
                        input logic [15:0] im, input logic ui);
      int n = 0;
      wait_idle();
      opcode = op; rdest = rd; rsrc = rs; imm = im; use_imm = ui; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      while (!done && n < 40) begin @(negedge clk); n++; end
      check("done_seen", done, 1'b1);
   endtask

   initial begin
      @(negedge clk); #1 reset = 1'b1;
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_bus", alu_bus, 16'h0);
      check("rst_en", reg_en, 16'h0);
      check("rst_flags", flags, 5'h00);
      run_checks = 1'b1;

      issue(4'd6, 4'd3, 4'd0, 16'h7FFF, 1'b1);
      issue(4'd6, 4'd4, 4'd0, 16'h0001, 1'b1);
      issue(4'd6, 4'd1, 4'd0, 16'h0005, 1'b1);
      issue(4'd6, 4'd5, 4'd0, 16'h0123, 1'b1);
      issue(4'd6, 4'd6, 4'd0, 16'h0456, 1'b1);

      issue(4'd0, 4'd3, 4'd4, 16'h0000, 1'b0);
      check("add_bus", alu_bus, 16'h8000);
      check("add_en", reg_en, 16'h0008);
      check("add_F", flags[2], 1'b1);
      check("add_C", flags[4], 1'b0);
      @(negedge clk);
      check("add_r3", regs_bus[3*16 +: 16], 16'h8000);

      issue(4'd2, 4'd1, 4'd0, 16'h0007, 1'b1);
      check("cmp_en", reg_en, 16'h0000);
      check("cmp_flags", flags, 5'h0D);
      @(negedge clk);
      check("cmp_r1", regs_bus[1*16 +: 16], 16'h0005);

      issue(4'd6, 4'd2, 4'd0, 16'h8001, 1'b1);
      issue(4'd7, 4'd2, 4'd0, 16'h001F, 1'b1);
      check("lsh_m1", alu_bus, 16'h4000);
      issue(4'd6, 4'd2, 4'd0, 16'h8001, 1'b1);
      issue(4'd8, 4'd2, 4'd0, 16'h001F, 1'b1);
      check("ash_m1", alu_bus, 16'hC000);
      issue(4'd6, 4'd2, 4'd0, 16'h8001, 1'b1);
      issue(4'd7, 4'd2, 4'd0, 16'h0004, 1'b1);
      check("lsh_p4", alu_bus, 16'h0010);
      issue(4'd6, 4'd2, 4'd0, 16'h8001, 1'b1);
      issue(4'd7, 4'd2, 4'd0, 16'h0010, 1'b1);
      check("lsh_m16", alu_bus, 16'h0000);
      issue(4'd6, 4'd2, 4'd0, 16'h8001, 1'b1);
      issue(4'd8, 4'd2, 4'd0, 16'h0010, 1'b1);
      check("ash_m16", alu_bus, 16'hFFFF);

      issue(4'd13, 4'd0, 4'd0, 16'h0000, 1'b0);
      check("ill_done", done, 1'b1);
      check("ill_en", reg_en, 16'h0000);
      check("ill_bus", alu_bus, 16'hFFFF);
      check("ill_flags", flags, 5'h0D);

      // 0x123 * 0x456 = 0x4EDC2; stray starts during busy must be dropped.
      wait_idle();
      opcode = 4'd9; rdest = 4'd5; rsrc = 4'd6; use_imm = 1'b0; start = 1'b1;
      @(negedge clk);
      for (int c = 1; c <= 17; c++) begin
         start  = (c == 3) || (c == 9);
         opcode = 4'd0;
         check("mul_busy", busy, 1'b1);
         check("mul_done", done, c == 17);
         if (c == 17) check("mul_bus", alu_bus, 16'hEDC2);
         @(negedge clk);
      end
      start = 1'b0;
      check("mul_r5", regs_bus[5*16 +: 16], 16'hEDC2);

      wait_idle();
      opcode = 4'd9; rdest = 4'd7; rsrc = 4'd6; use_imm = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (7) @(negedge clk);
      #1 reset = 1'b0;
      #2 reset = 1'b1;
      check("mrst_busy", busy, 1'b0);
      check("mrst_en", reg_en, 16'h0000);
      check("mrst_flags", flags, 5'h00);
      check("mrst_bus", alu_bus, 16'h0000);
      repeat (20) @(negedge clk);
      check("mrst_r7", regs_bus[7*16 +: 16], 16'h0000);
      issue(4'd0, 4'd3, 4'd4, 16'h0000, 1'b0);
      check("post_bus", alu_bus, 16'h8001);
      check("post_en", reg_en, 16'h0008);
      check("post_flags", flags, 5'h00);

      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         start   = ($urandom_range(0, 3) == 0);
         opcode  = 4'($urandom_range(0, 15));
         rdest   = 4'($urandom_range(0, 15));
         rsrc    = 4'($urandom_range(0, 15));
         imm     = 16'($urandom);
         use_imm = 1'($urandom_range(0, 1));
      end
      start = 1'b0;
      repeat (25) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
